// File: rtl/hq2x_line_writer_if.sv
// Pixel-stream inputs and line-store write / line-commit outputs of hq2x_line_writer.
// The master side drives the raw pixel stream; the slave side is the line writer.
interface hq2x_line_writer_if #(
    parameter int unsigned LENGTH = 858,
    parameter int unsigned DWIDTH = 23
);
    localparam int unsigned AWIDTH = (LENGTH <= 2)   ? 0 :
                                     (LENGTH <= 4)   ? 1 :
                                     (LENGTH <= 8)   ? 2 :
                                     (LENGTH <= 16)  ? 3 :
                                     (LENGTH <= 32)  ? 4 :
                                     (LENGTH <= 64)  ? 5 :
                                     (LENGTH <= 128) ? 6 :
                                     (LENGTH <= 256) ? 7 :
                                     (LENGTH <= 512) ? 8 :
                                     (LENGTH <= 1024) ? 9 : 10;

    logic              ce_pix;
    logic              hblank;
    logic              vblank;
    logic [DWIDTH:0]   pix_in;
    logic [AWIDTH:0]   wraddr;
    logic              wrbuf;
    logic [DWIDTH:0]   data;
    logic              wren;
    logic              line_rdy;
    logic              line_buf;
    logic [AWIDTH:0]   line_len;
    logic              frame_start;
    logic              ovf;

    modport master (
        output ce_pix, hblank, vblank, pix_in,
        input  wraddr, wrbuf, data, wren, line_rdy, line_buf, line_len, frame_start, ovf
    );

    modport slave (
        input  ce_pix, hblank, vblank, pix_in,
        output wraddr, wrbuf, data, wren, line_rdy, line_buf, line_len, frame_start, ovf
    );
endinterface

// File: rtl/hq2x_line_writer.sv
// Write-side controller for the hq2x double-buffered line store; commits each line to the reader.
// HQ2X_LW_LINE_LEN_EN: when defined line_len reports the measured length, else LENGTH-1.
module hq2x_line_writer #(
    parameter int unsigned LENGTH = 858,
    parameter int unsigned DWIDTH = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    hq2x_line_writer_if.slave bus_io
);
    localparam int unsigned AWIDTH = (LENGTH <= 2)   ? 0 :
                                     (LENGTH <= 4)   ? 1 :
                                     (LENGTH <= 8)   ? 2 :
                                     (LENGTH <= 16)  ? 3 :
                                     (LENGTH <= 32)  ? 4 :
                                     (LENGTH <= 64)  ? 5 :
                                     (LENGTH <= 128) ? 6 :
                                     (LENGTH <= 256) ? 7 :
                                     (LENGTH <= 512) ? 8 :
                                     (LENGTH <= 1024) ? 9 : 10;
    // One extra bit so the counter can hold LENGTH itself.
    localparam int unsigned CWIDTH = AWIDTH + 2;
    localparam logic [CWIDTH-1:0] CntMax = CWIDTH'(LENGTH);

    typedef enum logic [1:0] {StVbl, StAct, StHbl} state_e;

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH:0]   wraddr_q, wraddr_d;
    logic              wrbuf_q, wrbuf_d;
    logic [DWIDTH:0]   data_q, data_d;
    logic              wren_q, wren_d;
    logic              line_rdy_q, line_rdy_d;
    logic              line_buf_q, line_buf_d;
    logic [AWIDTH:0]   line_len_q, line_len_d;
    logic              frame_start_q, frame_start_d;
    logic              ovf_q, ovf_d;
    logic              first_q, first_d;

    logic pix_ev, blank_ev;
    assign pix_ev   = bus_io.ce_pix && !bus_io.hblank && !bus_io.vblank;
    assign blank_ev = bus_io.ce_pix && (bus_io.hblank || bus_io.vblank);

`ifdef HQ2X_LW_LINE_LEN_EN
    logic [CWIDTH-1:0] cnt_sat;
    assign cnt_sat = (cnt_q > CntMax) ? CntMax : cnt_q;
`else
    localparam logic [AWIDTH:0] LenMax = (AWIDTH + 1)'(LENGTH - 1);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wraddr_d      = wraddr_q;
        wrbuf_d       = wrbuf_q;
        data_d        = data_q;
        wren_d        = 1'b0;
        line_rdy_d    = 1'b0;
        line_buf_d    = line_buf_q;
        line_len_d    = line_len_q;
        frame_start_d = 1'b0;
        ovf_d         = 1'b0;
        first_d       = first_q;

        case (state_q)
            StVbl, StHbl: begin
                if (state_q == StVbl) first_d = 1'b1;
                if (pix_ev) begin
                    wren_d   = 1'b1;
                    wraddr_d = '0;
                    data_d   = bus_io.pix_in;
                    cnt_d    = CWIDTH'(1);
                    state_d  = StAct;
                end else if (state_q == StHbl && bus_io.ce_pix && bus_io.vblank) begin
                    state_d = StVbl;
                end
            end
            StAct: begin
                if (pix_ev) begin
                    if (cnt_q < CntMax) begin
                        wren_d   = 1'b1;
                        wraddr_d = cnt_q[AWIDTH:0];
                        data_d   = bus_io.pix_in;
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (blank_ev) begin
                    line_rdy_d    = 1'b1;
                    line_buf_d    = wrbuf_q;
`ifdef HQ2X_LW_LINE_LEN_EN
                    line_len_d    = (AWIDTH + 1)'(cnt_sat - 1'b1);
`else
                    line_len_d    = LenMax;
`endif
                    frame_start_d = first_q;
                    wrbuf_d       = ~wrbuf_q;
                    first_d       = 1'b0;
                    state_d       = bus_io.vblank ? StVbl : StHbl;
                end
            end
            default: state_d = StVbl;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StVbl;
            cnt_q         <= '0;
            wraddr_q      <= '0;
            wrbuf_q       <= 1'b0;
            data_q        <= '0;
            wren_q        <= 1'b0;
            line_rdy_q    <= 1'b0;
            line_buf_q    <= 1'b0;
            line_len_q    <= '0;
            frame_start_q <= 1'b0;
            ovf_q         <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wraddr_q      <= wraddr_d;
            wrbuf_q       <= wrbuf_d;
            data_q        <= data_d;
            wren_q        <= wren_d;
            line_rdy_q    <= line_rdy_d;
            line_buf_q    <= line_buf_d;
            line_len_q    <= line_len_d;
            frame_start_q <= frame_start_d;
            ovf_q         <= ovf_d;
            first_q       <= first_d;
        end
    end

    assign bus_io.wraddr      = wraddr_q;
    assign bus_io.wrbuf       = wrbuf_q;
    assign bus_io.data        = data_q;
    assign bus_io.wren        = wren_q;
    assign bus_io.line_rdy    = line_rdy_q;
    assign bus_io.line_buf    = line_buf_q;
    assign bus_io.line_len    = line_len_q;
    assign bus_io.frame_start = frame_start_q;
    assign bus_io.ovf         = ovf_q;
endmodule

// File: tb/tb_hq2x_line_writer.sv
// Directed bench for hq2x_line_writer: LENGTH=8, DWIDTH=7, ce_pix on every other cycle.
module tb_hq2x_line_writer;
    localparam int unsigned LENGTH = 8;
    localparam int unsigned DWIDTH = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hq2x_line_writer_if #(.LENGTH(LENGTH), .DWIDTH(DWIDTH)) bus ();

    hq2x_line_writer #(.LENGTH(LENGTH), .DWIDTH(DWIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        logic       hb;
        logic       vb;
        logic [7:0] px;
        logic       wren;
        logic [2:0] addr;
        logic       wrbuf;
        logic [7:0] data;
        logic       rdy;
        logic       lbuf;
        logic [2:0] len;
        logic       fs;
        logic       ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] len_exp(input logic [2:0] l);
`ifdef HQ2X_LW_LINE_LEN_EN
        return l;
`else
        return 3'(l - l + 3'(LENGTH - 1));
`endif
    endfunction

    // Accepted pixel written to (addr, buf).
    function automatic vec_t pw(input int px, input int a, input logic b);
        vec_t v = '{hb: 1'b0, vb: 1'b0, px: 8'(px), wren: 1'b1, addr: 3'(a), wrbuf: b,
                    data: 8'(px), rdy: 1'b0, lbuf: 1'b0, len: 3'd0, fs: 1'b0, ovf: 1'b0};
        return v;
    endfunction

    // Pixel dropped because the line is already full.
    function automatic vec_t dr(input int px, input logic b);
        vec_t v = pw(px, 0, b);
        v.wren = 1'b0;
        v.ovf  = 1'b1;
        return v;
    endfunction

    // Blank event that commits a line; nb is wrbuf after the flip.
    function automatic vec_t cm(input logic hb, input logic vb, input logic lb, input int len,
                                input logic fs, input logic nb);
        vec_t v = pw(8'hff, 0, nb);
        v.hb   = hb;
        v.vb   = vb;
        v.wren = 1'b0;
        v.rdy  = 1'b1;
        v.lbuf = lb;
        v.len  = len_exp(3'(len));
        v.fs   = fs;
        return v;
    endfunction

    // ce_pix event with blanking that must not write or commit.
    function automatic vec_t nop(input logic hb, input logic vb, input logic b);
        vec_t v = pw(8'hee, 0, b);
        v.hb   = hb;
        v.vb   = vb;
        v.wren = 1'b0;
        return v;
    endfunction

    // One ce_pix cycle followed by one idle cycle; outputs sampled 1ns after each edge.
    task automatic run(input vec_t v, input string tag);
        bus.ce_pix = 1'b1;
        bus.hblank = v.hb;
        bus.vblank = v.vb;
        bus.pix_in = v.px;
        @(posedge clk);
        #1;
        bus.ce_pix = 1'b0;
        chk({tag, ".wren"}, 32'(bus.wren), 32'(v.wren));
        chk({tag, ".wrbuf"}, 32'(bus.wrbuf), 32'(v.wrbuf));
        chk({tag, ".line_rdy"}, 32'(bus.line_rdy), 32'(v.rdy));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(v.ovf));
        if (v.wren) begin
            chk({tag, ".wraddr"}, 32'(bus.wraddr), 32'(v.addr));
            chk({tag, ".data"}, 32'(bus.data), 32'(v.data));
        end
        if (v.rdy) begin
            chk({tag, ".line_buf"}, 32'(bus.line_buf), 32'(v.lbuf));
            chk({tag, ".line_len"}, 32'(bus.line_len), 32'(v.len));
        end
        chk({tag, ".frame_start"}, 32'(bus.frame_start), 32'(v.rdy & v.fs));
        @(posedge clk);
        #1;
        chk({tag, ".idle_wren"}, 32'(bus.wren), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(bus.line_rdy), 32'd0);
        chk({tag, ".idle_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wren"}, 32'(bus.wren), 32'd0);
        chk({tag, ".wraddr"}, 32'(bus.wraddr), 32'd0);
        chk({tag, ".wrbuf"}, 32'(bus.wrbuf), 32'd0);
        chk({tag, ".data"}, 32'(bus.data), 32'd0);
        chk({tag, ".line_rdy"}, 32'(bus.line_rdy), 32'd0);
        chk({tag, ".line_buf"}, 32'(bus.line_buf), 32'd0);
        chk({tag, ".line_len"}, 32'(bus.line_len), 32'd0);
        chk({tag, ".frame_start"}, 32'(bus.frame_start), 32'd0);
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        bus.ce_pix = 1'b0;
        bus.hblank = 1'b0;
        bus.vblank = 1'b1;
        bus.pix_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(nop(1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) tbl.push_back(pw(8'h10 + i, i, 1'b0));
        tbl.push_back(cm(1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b1));
        tbl.push_back(nop(1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(pw(8'h20 + i, i, 1'b1));
        tbl.push_back(cm(1'b1, 1'b0, 1'b1, 7, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) tbl.push_back(pw(8'h30 + i, i, 1'b0));
        tbl.push_back(dr(8'h38, 1'b0));
        tbl.push_back(dr(8'h39, 1'b0));
        tbl.push_back(cm(1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++) tbl.push_back(pw(8'h40 + i, i, 1'b1));
        tbl.push_back(cm(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0));
        tbl.push_back(nop(1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) tbl.push_back(pw(8'h50 + i, i, 1'b0));
        tbl.push_back(cm(1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1));
        tbl.push_back(nop(1'b0, 1'b1, 1'b1));
        tbl.push_back(pw(8'h60, 0, 1'b1));
        tbl.push_back(cm(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0));
        tbl.push_back(pw(8'h70, 0, 1'b0));
        tbl.push_back(cm(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1));

        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // Reset in the middle of a line written to buffer 1.
        for (int i = 0; i < 4; i++) run(pw(8'h80 + i, i, 1'b1), $sformatf("pre_rst%0d", i));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midline_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.line_rdy", 32'(bus.line_rdy), 32'd0);
        run(nop(1'b1, 1'b0, 1'b0), "post_rst.hblank_in_vbl");
        run(pw(8'h90, 0, 1'b0), "post_rst.p0");
        run(pw(8'h91, 1, 1'b0), "post_rst.p1");
        run(cm(1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1), "post_rst.commit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hq2x_line_writer.md
# hq2x_line_writer

Upstream write-side controller for the hq2x double-buffered line store. Takes the raw pixel stream (pixel enable plus blanking) and drives the line store's write port: address, buffer select, data and write enable. At each line end it flips the write buffer and hands the just-completed buffer, with its measured length, to the hq2x read/filter side.

## Interface
- LENGTH, 858: maximum pixels per line; must match the line store's LENGTH.
- DWIDTH, 23: MSB index of a pixel word (word width DWIDTH+1).
- AWIDTH (localparam): same LENGTH ladder as the line store (0 for ≤2 … 9 for ≤1024, else 10); address width AWIDTH+1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ce_pix  in  1  pixel enable; inputs below are sampled only when high.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- pix_in  in  DWIDTH+1  pixel word.
- wraddr  out  AWIDTH+1  line-store write address.
- wrbuf  out  1  line-store buffer being written.
- data  out  DWIDTH+1  line-store write data.
- wren  out  1  line-store write strobe.
- line_rdy  out  1  one-cycle pulse: a line has been committed.
- line_buf  out  1  buffer index holding the committed line.
- line_len  out  AWIDTH+1  committed line pixel count minus one.
- frame_start  out  1  one-cycle pulse, coincident with line_rdy for the first line after vblank.
- ovf  out  1  one-cycle pulse: a pixel was dropped because the line exceeded LENGTH.

## Operation
- All outputs registered. Reset: state VBL, wraddr=0, wrbuf=0, data=0, wren=0, line_rdy=0, line_buf=0, line_len=0, frame_start=0, ovf=0, internal first-line flag=1, pixel counter=0.
- "Pixel event" = ce_pix && !hblank && !vblank. "Blank event" = ce_pix && (hblank || vblank).
- VBL: first-line flag set. On pixel event: write pix_in at address 0, counter←1, go ACT. Otherwise stay.
- ACT: on pixel event, if counter ≤ LENGTH-1: write at address counter, counter+1; else drop pixel, pulse ovf, counter holds. On blank event: commit, then go HBL if !vblank, VBL if vblank.
- HBL: on pixel event: write at address 0, counter←1, go ACT. On ce_pix && vblank: go VBL (no commit).
- Commit: line_rdy=1, line_buf=current wrbuf, line_len=min(counter,LENGTH)-1, frame_start=first-line flag; wrbuf toggles; first-line flag cleared.
- Lines are never zero-length: ACT is entered only by a write.
- Counter saturates at LENGTH; never wraps. wraddr never exceeds LENGTH-1.
- ce_pix low: no state change, no writes.
- Reset mid-line: partial line discarded, no commit pulse; restart in VBL with wrbuf=0.

## Timing
- Pixel event sampled at edge N → wren=1, wraddr, data, wrbuf valid during cycle N+1; wren is high exactly one cycle per accepted pixel.
- Blank event in ACT at edge N → line_rdy/line_buf/line_len/frame_start valid in cycle N+1, wrbuf shows new value in N+1. line_rdy is high one cycle.
- Write of the last pixel and the commit are always on different edges (distinct ce_pix events), so the last word is in the store before line_rdy.
- ovf pulses in the cycle after the dropped pixel's edge; wren stays 0 then.
- Consumer may read line_buf from line_rdy onward until the next line_rdy.

## Configuration
- HQ2X_LW_LINE_LEN_EN defined: line_len reports measured length as above.
- Undefined: counter-to-line_len path removed; line_len is constant LENGTH-1; ovf and saturation unchanged.

## Test plan
Bench uses LENGTH=8, DWIDTH=7, ce_pix every 2nd cycle, HQ2X_LW_LINE_LEN_EN defined unless stated.
- Reset then vblank low, 5 pixels 0x10..0x14, hblank → writes addr 0..4 to buf 0, line_rdy with line_buf=0, line_len=4, frame_start=1, wrbuf=1 after.
- Second line of 8 pixels → writes to buf 1, line_len=7, line_buf=1, frame_start=0, wrbuf back to 0.
- Line of 10 pixels → addr 0..7 written, two ovf pulses, no wren for pixels 9–10, line_len=7.
- vblank asserted mid-line after 3 pixels → commit line_len=2, state VBL; next line gives frame_start=1.
- rst_n low after 4 pixels → all outputs 0 immediately, no line_rdy; next line writes buf 0 from addr 0.
- Macro undefined, 5-pixel line → line_len=7, writes and line_rdy identical to first scenario.
